// File: rtl/range_result_serializer_if.sv
// Narrow valid/ready beat stream carrying one serialized range result toward the pins.
interface range_result_serializer_if #(
    parameter int unsigned OUT_W = 8
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             out_error;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_error,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_error,
        output out_ready
    );
endinterface

// File: rtl/range_result_serializer.sv
// Captures the final range word and error flag after a finish strobe and streams it MSB-chunk-first.
module range_result_serializer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned OUT_W = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               range_in,
    input  logic                           error_in,
    input  logic                           finish,
    range_result_serializer_if.master      out,
    output logic                           busy,
    output logic                           overrun
);
    localparam int unsigned NBEATS = WIDTH / OUT_W;
    localparam int unsigned CNT_W  = $clog2(NBEATS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               ovr_q, ovr_d;
    logic               last_beat;

    assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        // A finish seen outside IDLE is dropped but remembered until reset.
        ovr_d   = ovr_q | (finish && (state_q != IDLE));
        case (state_q)
            IDLE: begin
                if (finish) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                // Upstream range settles one edge after finish, so capture here.
                state_d = SEND;
                shift_d = range_in;
                err_d   = error_in;
                cnt_d   = '0;
            end
            SEND: begin
                if (out.out_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        shift_d = shift_q << OUT_W;
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign out.out_data  = shift_q[WIDTH-1 -: OUT_W];
    assign out.out_valid = (state_q == SEND);
    assign out.out_last  = (state_q == SEND) && last_beat;
    assign out.out_error = (state_q == SEND) && err_q;
    assign busy          = (state_q != IDLE);
    assign overrun       = ovr_q;
endmodule

// File: doc/range_result_serializer.md
Name: range_result_serializer

Overview:
- Sits directly downstream of the range-finder stage.
- Captures the final range value and the debug error flag when a measurement run ends.
- Streams the result MSB-chunk-first over a narrow valid/ready output port toward the chip pins.
- Tolerates output backpressure and flags results that arrive while a previous frame is still being sent.

Parameters:
- WIDTH, 16: width of the incoming range word.
- OUT_W, 8: width of each output beat. WIDTH must be an integer multiple of OUT_W; NBEATS = WIDTH/OUT_W, at least 1.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- range_in  input  WIDTH  range value from the upstream finder.
- error_in  input  1  debug error flag from the upstream finder.
- finish  input  1  same finish strobe that drives the upstream finder.
- out_ready  input  1  consumer accepts the current beat.
- out_data  output  OUT_W  current beat; highest unsent chunk of the captured word.
- out_valid  output  1  out_data holds a valid beat.
- out_last  output  1  current beat is the final beat of the frame.
- out_error  output  1  captured error_in, held for the whole frame.
- busy  output  1  high whenever state is not IDLE.
- overrun  output  1  sticky: a finish arrived while a frame was pending or being sent.

Behaviour:
- Reset, synchronous: state=IDLE, shift register=0, beat count=0, captured error=0. All outputs read 0 in the cycle after the reset edge. A reset asserted mid-frame aborts the frame; the partial frame is not resumed.
- State machine, states IDLE, ARM, SEND:
  - IDLE: finish=1 at an edge moves to ARM. No capture happens at this edge.
  - ARM: lasts exactly one cycle. The upstream range settles one edge after finish, so at the ARM->SEND edge the block captures range_in into the shift register and error_in into the captured error, and sets beat count=0.
  - SEND: out_valid=1. out_data = shift register bits [WIDTH-1 -: OUT_W]. A transfer occurs at an edge where out_valid and out_ready are both 1.
    - Non-last transfer: shift left by OUT_W with zero fill, beat count+1.
    - Last transfer (beat count==NBEATS-1): next state IDLE.
- out_last = (state==SEND) and (beat count==NBEATS-1).
- out_error = captured error while in SEND, else 0.
- Latency: finish high in cycle T gives out_valid high from cycle T+2. With out_ready held high, a frame occupies NBEATS cycles, and IDLE is re-entered after the last transfer edge.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_last and out_error stay stable. out_valid never drops before the transfer completes.
- finish sampled while in ARM or SEND: ignored (no recapture, frame unaffected); overrun set to 1. overrun clears only on reset.
- finish in the same cycle as the last transfer: still SEND at that edge, so it counts as overrun and is dropped. A new frame needs finish sampled in IDLE.
- out_ready while out_valid=0: ignored.
- Arithmetic: none beyond the shift and a beat counter of width $clog2(NBEATS)+1. No wrap, because the count resets on every capture.

Test Plan:
- Basic frame, WIDTH=16, OUT_W=8: range_in=0x1234, finish pulse in cycle T, out_ready=1 -> out_valid from T+2; beats 0x12 (out_last=0) then 0x34 (out_last=1); busy low from T+4.
- Backpressure: range_in=0xBEEF, out_ready low 3 cycles after out_valid rises -> out_data stays 0xBE for those cycles; out_ready=1 gives 0xBE then 0xEF with out_last on 0xEF.
- Error capture: error_in=1 during ARM, range_in=0x00FF -> out_error=1 on both beats; next frame with error_in=0 gives out_error=0.
- Overrun: second finish pulse while the first frame is in SEND with out_ready=0 -> frame data unchanged, overrun=1 and remains 1 through later clean frames until reset.
- Capture timing: range_in=0x1111 in the finish cycle and 0x2222 in the ARM cycle -> transmitted word is 0x2222.
- Reset mid-frame: assert reset after the first beat of 0xA5C3 -> next cycle out_valid=0, busy=0, overrun=0; a fresh finish with 0x0102 sends 0x01, 0x02.
